keccak_chi_dom: RTL and testbench
=================================

Name: keccak_chi_dom

Overview:
- DOM-masked (domain-oriented masking) Keccak chi step, registered, with valid/ready handshake.
- Sits directly downstream of the combinational rho/pi stage and consumes its N-share masked state.
- Fresh randomness is consumed only on an accepted transfer.
- Output feeds iota/round logic, which remains outside this block.

Parameters:
- W, 16, lane width in bits (1, 2, 4, 8, 16, 32, 64).
- N, 2, number of shares (2..4); protection order N-1.

Ports:
- ClkxCI  in  1  clock
- RstxRBI  in  1  synchronous active-low reset
- StatexDI  in  N*25*W  masked state.
  - Share s occupies [s*25*W +: 25*W].
  - Lane (x,y) within a share occupies [(5*x+y)*W +: W].
- ZxDI  in  (N*(N-1)/2)*25*W  fresh randomness, one 25*W slice per share pair p.
  - Pairs are ordered (0,1),(0,2),..,(0,N-1),(1,2),..
- InValidxSI  in  1  StatexDI and ZxDI valid
- InReadyxSO  out  1  block accepts input this cycle
- StatexDO  out  N*25*W  masked chi result, same layout as StatexDI
- OutValidxSO  out  1  StatexDO valid
- OutReadyxSI  in  1  downstream accepts output

Behaviour:
- Unmasked function, per lane bit:
  - out(x,y) = a(x,y) ^ (~a(x+1,y) & a(x+2,y)).
  - x indices are taken mod 5.
- Per bit, the AND of b = a(x+1,y) and c = a(x+2,y) is a DOM-indep gadget.
  - Negation is applied to share 0 of b only.
- Inner-domain register, share i:
  - Ri <= a_i ^ (b'_i & c_i).
  - b'_0 = ~b_0; b'_i = b_i for i > 0.
- Cross-domain register, i != j:
  - Cij <= (b'_i & c_j) ^ Z_p, where p = pair(min(i,j), max(i,j)).
  - Cij and Cji share the same Z slice.
- Output share i is combinational: Ri ^ XOR over j != i of Cij.
  - No logic is permitted between the registers and the XOR tree beyond this.
- Latency: exactly 1 cycle from accepted input to OutValidxSO=1 carrying the result.
- Handshake:
  - InReadyxSO = ~OutValidxSO | OutReadyxSI. This path is combinational; there is no path from InValidxSI to InReadyxSO.
  - Load: all R/C registers capture on InValidxSI & InReadyxSO.
  - OutValidxSO becomes 1 on load.
  - OutValidxSO becomes 0 when OutValidxSI & OutReadyxSI occur with no simultaneous load.
  - Simultaneous output accept and input load: registers take the new data and OutValidxSO stays 1. Full throughput is one state per cycle.
  - Stall (OutValidxSO=1, OutReadyxSI=0):
    - Registers hold.
    - StatexDO is stable.
    - ZxDI and StatexDI are ignored.
- Reset (RstxRBI=0 at a clock edge):
  - All R/C registers clear to 0.
  - StatexDO=0, OutValidxSO=0, InReadyxSO=1 after the edge.
  - Reset mid-stall discards the held result; no output handshake completes in the reset cycle.
- Security rules:
  - Cross-domain terms must be registered before any XOR with other domains.
  - Share i logic must never combine two shares of the same variable unregistered.
  - No glitch path may exist from StatexDI to StatexDO.
- Width: all arithmetic is bitwise; no carries; W does not need to be a power of two but is listed as such.

Decomposition:
- Shared package keccak_dom_pkg contains:
  - the lane index function Idx(x,y) = (5*x+y)*W;
  - the share-pair index function pair(i,j) for i<j;
  - a localparam for pair count N*(N-1)/2.
  - The existing rho/pi stage uses the same Idx definition, so both stages share one layout.
- One sub-module: keccak_dom_and. It is a W-bit vector DOM-indep AND with N shares, registered outputs, load enable and sync reset, and handles the share-0 negation flag.
- keccak_chi_dom instantiates 25 of these, one per lane, plus the linear-term merge into the inner registers and the handshake logic.

Test Plan (W=16, N=2 unless stated; unmasked = XOR of shares):
- Zero state:
  - Stimulus: shares random but XOR to 0, Z random, one transfer.
  - Response: unmasked StatexDO = 0 one cycle after accept; OutValidxSO=1 for that cycle with OutReadyxSI=1.
- Single bit:
  - Stimulus: unmasked lane (0,0) = 16'h0001, all other lanes 0.
  - Response: unmasked output has lane (0,0) = 16'h0001 and lane (3,0) = 16'h0001; all other lanes are 0.
- All ones:
  - Stimulus: unmasked state all 1s.
  - Response: unmasked output all 1s.
  - Repeat with 3 different Z values: unmasked result identical, while individual output shares differ.
- Back-pressure:
  - Stimulus: two states streamed back-to-back with OutReadyxSI=0 for 3 cycles.
  - Response:
    - InReadyxSO=0 during the stall.
    - The first result is held bit-stable.
    - The second input is taken on the cycle OutReadyxSI rises.
    - Both results are correct and in order; no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert RstxRBI=0 while OutValidxSO=1 and stalled.
  - Response: next cycle OutValidxSO=0, StatexDO=0, InReadyxSO=1; the held result is never accepted.
- N=3 random regression:
  - Stimulus: 1000 random states and Z values with random valid/ready toggling.
  - Response: unmasked outputs match a reference chi model, in order, with count equal to input count.

Source files
------------

// File: rtl/keccak_dom_pkg.sv
// keccak_dom_pkg: shared state layout and share-pair indexing for the masked Keccak stages.
package keccak_dom_pkg;

    localparam int MAX_SHARES = 4;
    localparam int MAX_PAIRS  = MAX_SHARES * (MAX_SHARES - 1) / 2;

    function automatic int npairs(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Bit offset of lane (x,y) inside one share; the rho/pi stage uses the same layout.
    function automatic int Idx(input int x, input int y, input int w);
        return (5 * x + y) * w;
    endfunction

    // Pairs ordered (0,1),(0,2),..,(0,n-1),(1,2),..; valid for i < j.
    function automatic int pair(input int i, input int j, input int n);
        return i * (2 * n - i - 1) / 2 + j - i - 1;
    endfunction

endpackage

// File: rtl/keccak_dom_and.sv
// keccak_dom_and: W-bit DOM-indep AND over N shares with registered domain terms and a linear-term merge.
module keccak_dom_and
    import keccak_dom_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    input  logic                      neg_i,
    input  logic [N*W-1:0]            lin_i,
    input  logic [N*W-1:0]            b_i,
    input  logic [N*W-1:0]            c_i,
    input  logic [(N*(N-1)/2)*W-1:0]  z_i,
    output logic [N*W-1:0]            q_o
);

    // t_q[i][i] holds the inner-domain term Ri, t_q[i][j] (i != j) the cross-domain term Cij
    logic [W-1:0] t_q [N][N];
    logic [W-1:0] t_d [N][N];

    function automatic int pidx(input int i, input int j);
        return i < j ? pair(i, j, N) : (j < i ? pair(j, i, N) : 0);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                t_d[i][j] = ((b_i[i*W +: W] ^ {W{neg_i && i == 0}}) & c_i[j*W +: W])
                          ^ (i == j ? lin_i[i*W +: W] : z_i[pidx(i, j)*W +: W]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) t_q <= '{default: '0};
        else if (en_i) t_q <= t_d;
    end

    always_comb begin
        q_o = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                q_o[i*W +: W] = q_o[i*W +: W] ^ t_q[i][j];
            end
        end
    end

endmodule

// File: rtl/keccak_chi_dom.sv
// keccak_chi_dom: registered DOM-masked Keccak chi step with a one-deep valid/ready output stage.
module keccak_chi_dom
    import keccak_dom_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 2
) (
    input  logic                         ClkxCI,
    input  logic                         RstxRBI,
    input  logic [N*25*W-1:0]            StatexDI,
    input  logic [(N*(N-1)/2)*25*W-1:0]  ZxDI,
    input  logic                         InValidxSI,
    output logic                         InReadyxSO,
    output logic [N*25*W-1:0]            StatexDO,
    output logic                         OutValidxSO,
    input  logic                         OutReadyxSI
);

    localparam int NP = npairs(N);
    localparam int SW = 25 * W;

    logic out_valid_q, out_valid_d, load;

    assign InReadyxSO  = ~out_valid_q | OutReadyxSI;
    assign load        = InValidxSI & InReadyxSO;
    assign OutValidxSO = out_valid_q;

    always_comb out_valid_d = load | (out_valid_q & ~OutReadyxSI);

    always_ff @(posedge ClkxCI) begin
        if (!RstxRBI) out_valid_q <= 1'b0;
        else out_valid_q <= out_valid_d;
    end

    for (genvar x = 0; x < 5; x++) begin : g_x
        for (genvar y = 0; y < 5; y++) begin : g_y
            logic [N*W-1:0]  lin, b, c, q;
            logic [NP*W-1:0] z;
            for (genvar s = 0; s < N; s++) begin : g_s
                assign lin[s*W +: W] = StatexDI[s*SW + Idx(x, y, W) +: W];
                assign b[s*W +: W]   = StatexDI[s*SW + Idx((x + 1) % 5, y, W) +: W];
                assign c[s*W +: W]   = StatexDI[s*SW + Idx((x + 2) % 5, y, W) +: W];
                assign StatexDO[s*SW + Idx(x, y, W) +: W] = q[s*W +: W];
            end
            for (genvar p = 0; p < NP; p++) begin : g_p
                assign z[p*W +: W] = ZxDI[p*SW + Idx(x, y, W) +: W];
            end
            // chi complements b, so share 0 of b enters the gadget inverted
            keccak_dom_and #(.W(W), .N(N)) u_and (
                .clk_i  (ClkxCI),
                .rst_ni (RstxRBI),
                .en_i   (load),
                .neg_i  (1'b1),
                .lin_i  (lin),
                .b_i    (b),
                .c_i    (c),
                .z_i    (z),
                .q_o    (q)
            );
        end
    end

endmodule

// File: tb/tb_keccak_chi_dom.sv
// tb_keccak_chi_dom: scoreboard bench for the masked chi step, N=2 directed cases plus an N=3 random stream.
module tb_keccak_chi_dom;

    localparam int W = 16;
    localparam int L = 25 * W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2*L-1:0] st2 = '0, so2;
    logic [L-1:0]   z2 = '0;
    logic           iv2 = 1'b0, ir2, ov2, or2 = 1'b1;
    logic [3*L-1:0] st3 = '0, z3 = '0, so3;
    logic           iv3 = 1'b0, ir3, ov3, or3 = 1'b1;

    int checks = 0, passes = 0, sent3 = 0, got3 = 0;
    bit rnd3 = 1'b0;
    logic [L-1:0] q2[$], q3[$];
    logic [L-1:0] last_sh0_2 = '0;

    keccak_chi_dom #(.W(W), .N(2)) dut2 (
        .ClkxCI(clk), .RstxRBI(rst_n), .StatexDI(st2), .ZxDI(z2), .InValidxSI(iv2),
        .InReadyxSO(ir2), .StatexDO(so2), .OutValidxSO(ov2), .OutReadyxSI(or2)
    );

    keccak_chi_dom #(.W(W), .N(3)) dut3 (
        .ClkxCI(clk), .RstxRBI(rst_n), .StatexDI(st3), .ZxDI(z3), .InValidxSI(iv3),
        .InReadyxSO(ir3), .StatexDO(so3), .OutValidxSO(ov3), .OutReadyxSI(or3)
    );

    task automatic chk(input string name, input logic [L-1:0] act, input logic [L-1:0] e);
        checks++;
        if (act === e) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, e);
    endtask

    task automatic chkb(input string name, input logic act, input logic e);
        checks++;
        if (act === e) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, e);
    endtask

    function automatic logic [L-1:0] rnd();
        logic [L-1:0] r = '0;
        for (int i = 0; i < 13; i++) r = {r[L-33:0], $urandom()};
        return r;
    endfunction

    function automatic int lane(input int x, input int y);
        return (5 * x + y) * W;
    endfunction

    function automatic logic [L-1:0] chi(input logic [L-1:0] a);
        logic [L-1:0] o = '0;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[lane(x, y) +: W] = a[lane(x, y) +: W]
                    ^ (~a[lane((x + 1) % 5, y) +: W] & a[lane((x + 2) % 5, y) +: W]);
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst_n && ov2 && or2) begin
            if (q2.size() == 0) begin
                checks++;
                $display("FAIL out2: unexpected output %h", so2[0 +: L] ^ so2[L +: L]);
            end else chk("out2", so2[0 +: L] ^ so2[L +: L], q2.pop_front());
            last_sh0_2 = so2[0 +: L];
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov3 && or3) begin
            got3++;
            if (q3.size() == 0) begin
                checks++;
                $display("FAIL out3: unexpected output %h", so3[0 +: L] ^ so3[L +: L] ^ so3[2*L +: L]);
            end else chk("out3", so3[0 +: L] ^ so3[L +: L] ^ so3[2*L +: L], q3.pop_front());
        end
    end

    always @(posedge clk) if (rnd3) #1 or3 = ($urandom_range(3) != 0);

    task automatic send2(input logic [L-1:0] u, input logic [L-1:0] m, input logic [L-1:0] z,
                         input bit push, input logic [L-1:0] e);
        int k = 0;
        st2 = {m, u ^ m};
        z2 = z;
        iv2 = 1'b1;
        @(negedge clk);
        while (!ir2 && k < 100) begin @(negedge clk); k++; end
        if (!ir2) chkb("send2 timeout", ir2, 1'b1);
        else if (push) q2.push_back(e);
        @(posedge clk);
        #1 iv2 = 1'b0;
    endtask

    task automatic send3(input logic [L-1:0] u);
        logic [L-1:0] m1 = rnd(), m2 = rnd();
        int k = 0;
        st3 = {m2, m1, u ^ m1 ^ m2};
        z3 = {rnd(), rnd(), rnd()};
        iv3 = 1'b1;
        @(negedge clk);
        while (!ir3 && k < 100) begin @(negedge clk); k++; end
        if (!ir3) chkb("send3 timeout", ir3, 1'b1);
        else begin q3.push_back(chi(u)); sent3++; end
        @(posedge clk);
        #1 iv3 = 1'b0;
    endtask

    task automatic drain2();
        int k = 0;
        while (q2.size() != 0 && k < 100) begin @(negedge clk); k++; end
        chkb("drain2", q2.size() == 0, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [L-1:0] e, a, b, mfix;
        logic [L-1:0] sh [3];
        logic [2*L-1:0] held;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkb("rst ov2", ov2, 1'b0);
        chkb("rst ir2", ir2, 1'b1);
        chk("rst so2 sh0", so2[0 +: L], '0);
        chk("rst so2 sh1", so2[L +: L], '0);
        chkb("rst ov3", ov3, 1'b0);
        chk("rst so3 sh2", so3[2*L +: L], '0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        send2('0, rnd(), rnd(), 1'b1, '0);
        @(negedge clk);
        chkb("zero ov2 high", ov2, 1'b1);
        @(negedge clk);
        chkb("zero ov2 drops", ov2, 1'b0);
        @(posedge clk);
        #1;

        e = '0;
        e[0] = 1'b1;
        e[240] = 1'b1;
        a = '0;
        a[0] = 1'b1;
        send2(a, rnd(), rnd(), 1'b1, e);
        drain2();

        mfix = rnd();
        for (int k = 0; k < 3; k++) begin
            send2('1, mfix, rnd(), 1'b1, '1);
            drain2();
            sh[k] = last_sh0_2;
        end
        chkb("ones share differs 01", sh[0] != sh[1], 1'b1);
        chkb("ones share differs 12", sh[1] != sh[2], 1'b1);
        chkb("ones share differs 02", sh[0] != sh[2], 1'b1);

        a = rnd();
        b = rnd();
        or2 = 1'b0;
        send2(a, rnd(), rnd(), 1'b1, chi(a));
        st2 = {mfix, b ^ mfix};
        z2 = rnd();
        iv2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) held = so2;
            chkb("bp ready low", ir2, 1'b0);
            chkb("bp hold", so2 === held, 1'b1);
            chkb("bp ov2", ov2, 1'b1);
        end
        @(posedge clk);
        #1 or2 = 1'b1;
        @(negedge clk);
        chkb("bp take second", ir2, 1'b1);
        q2.push_back(chi(b));
        @(posedge clk);
        #1 iv2 = 1'b0;
        drain2();

        or2 = 1'b0;
        send2(rnd(), rnd(), rnd(), 1'b0, '0);
        @(negedge clk);
        chkb("stall before reset", ov2, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chkb("mid rst ov2", ov2, 1'b0);
        chkb("mid rst ir2", ir2, 1'b1);
        chk("mid rst sh0", so2[0 +: L], '0);
        chk("mid rst sh1", so2[L +: L], '0);
        @(posedge clk);
        #1 or2 = 1'b1;

        rnd3 = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            repeat ($urandom_range(1)) begin @(posedge clk); #1; end
            send3(rnd());
        end
        rnd3 = 1'b0;
        @(posedge clk);
        #1 or3 = 1'b1;
        for (int k = 0; k < 200 && q3.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        chk("n3 count", L'(got3), L'(sent3));
        chkb("n3 queue empty", q3.size() == 0, 1'b1);
        chkb("n2 queue empty", q2.size() == 0, 1'b1);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
